// File: rtl/breadboard_pkg.sv
// Shared constants for the breadboard sweeper: default geometry and FSM state codes.
package breadboard_pkg;
    localparam int DEF_NIN  = 4;
    localparam int DEF_NOUT = 10;
    localparam int DEPTH    = 2**DEF_NIN;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t SWEEP = 1'b1;
endpackage

// File: rtl/breadboard_lut_bank.sv
// NOUT run-time-loadable truth tables; synchronous write, combinational read of one code across all tables.
module breadboard_lut_bank #(
    parameter int NIN  = 4,
    parameter int NOUT = 10,
    parameter int SELW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [SELW-1:0]      sel,
    input  logic [2**NIN-1:0]    data,
    input  logic [NIN-1:0]       rd_idx,
    output logic [NOUT-1:0]      rd_vec
);
    for (genvar j = 0; j < NOUT; j++) begin : g_fn
        logic [2**NIN-1:0] tbl;

        always_ff @(posedge clk) begin
            if (rst)
                tbl <= '0;
            else if (we && sel == SELW'(j))
                tbl <= data;
        end

        assign rd_vec[j] = tbl[rd_idx];
    end
endmodule

// File: rtl/breadboard_sweeper.sv
// Clocked LUT breadboard: streamed lookups plus a sweep engine that emits every input code in order.
module breadboard_sweeper
    import breadboard_pkg::*;
#(
    parameter int  NIN  = DEF_NIN,
    parameter int  NOUT = DEF_NOUT,
    localparam int SELW = (NOUT > 1) ? $clog2(NOUT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [SELW-1:0]    cfg_sel,
    input  logic [2**NIN-1:0]  cfg_data,
    output logic               cfg_err,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NIN-1:0]     in_vec,
    input  logic               sweep_start,
    output logic               sweep_busy,
    output logic               sweep_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NOUT-1:0]    out_vec,
    output logic [NIN-1:0]     out_idx,
    output logic               out_last
);
    state_t          state;
    logic [NIN-1:0]  cnt;
    logic [NIN-1:0]  rd_idx;
    logic [NOUT-1:0] rd_vec;
    logic            load, stream_acc, sweep_beat, last_hs, cfg_ok;

    assign load       = !out_valid || out_ready;
    assign in_ready   = (state == IDLE) && load;
    assign stream_acc = in_valid && in_ready;
    // Once the final beat sits in the register, no further beats load until it drains.
    assign sweep_beat = (state == SWEEP) && load && !(out_valid && out_last);
    assign last_hs    = (state == SWEEP) && out_valid && out_ready && out_last;
    assign cfg_ok     = cfg_we && (state == IDLE) && (32'(cfg_sel) < NOUT);
    assign rd_idx     = stream_acc ? in_vec : cnt;
    assign sweep_busy = (state == SWEEP);

    // Read happens in the same cycle as any write, so a concurrent lookup sees the old table.
    breadboard_lut_bank #(.NIN(NIN), .NOUT(NOUT), .SELW(SELW)) u_bank (
        .clk    (clk),
        .rst    (rst),
        .we     (cfg_ok),
        .sel    (cfg_sel),
        .data   (cfg_data),
        .rd_idx (rd_idx),
        .rd_vec (rd_vec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_vec    <= '0;
            out_idx    <= '0;
            out_last   <= 1'b0;
            cfg_err    <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            cfg_err    <= cfg_we && !cfg_ok;
            sweep_done <= last_hs;

            case (state)
                IDLE:    if (sweep_start) state <= SWEEP;
                SWEEP:   if (last_hs) state <= IDLE;
                default: state <= IDLE;
            endcase

            // Counter holds at the top code rather than wrapping; it restarts from 0 via IDLE.
            if (state == IDLE)
                cnt <= '0;
            else if (sweep_beat && !(&cnt))
                cnt <= cnt + 1'b1;

            if (load) begin
                out_valid <= stream_acc || sweep_beat;
                out_last  <= sweep_beat && (&cnt);
                if (stream_acc || sweep_beat) begin
                    out_vec <= rd_vec;
                    out_idx <= rd_idx;
                end
            end
        end
    end
endmodule
